frc_readout_ctrl: RTL and testbench
===================================

FRC_READOUT_CTRL -- requirements
Module: frc_readout_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 6, meaning settle cycles after both force buffers report empty.
REQ-002 SHALL have parameter PARTICLE_ID_WIDTH, default MD_pkg value, meaning cache address width.
REQ-003 SHALL have port clk  in  1  the single clock for all logic.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have port i_start  in  1  one-cycle request to read out both force caches.
REQ-006 SHALL have port i_num_particles  in  PARTICLE_ID_WIDTH+1  count of particles to read, sampled on accepted i_start.
REQ-007 SHALL have port i_force_done  in  1  level; high when upstream force pipelines have no more forces to issue.
REQ-008 SHALL have port i_home_buf_empty  in  1  home force input buffer empty.
REQ-009 SHALL have port i_nb_buf_empty  in  1  neighbour force input buffer empty.
REQ-010 SHALL have port i_mu_ready  in  1  motion-update consumer can accept one force next cycle.
REQ-011 SHALL have port o_MU_rd_addr  out  PARTICLE_ID_WIDTH  force cache read/clear address.
REQ-012 SHALL have port o_MU_rd_en  out  1  force cache read-and-clear strobe.
REQ-013 SHALL have port o_frc_parid  out  PARTICLE_ID_WIDTH  address of the force word returned this cycle.
REQ-014 SHALL have port o_frc_parid_valid  out  1  force word plus o_frc_parid valid this cycle.
REQ-015 SHALL have port o_busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port o_done  out  1  one-cycle pulse when readout completes.

Function
REQ-017 SHALL implement states IDLE, DRAIN, SETTLE, READ, DONE.
REQ-018 IDLE: accept i_start, latch i_num_particles into cnt_max, clear addr counter, go to DRAIN; i_start in any other state is ignored.
REQ-019 DRAIN: go to SETTLE when i_force_done & i_home_buf_empty & i_nb_buf_empty, loading settle counter with DRAIN_CYCLES-1.
REQ-020 SETTLE: decrement each cycle; if either buffer goes non-empty, return to DRAIN; at count 0 with both buffers still empty, go to READ (go to DONE if cnt_max==0).
REQ-021 READ: o_MU_rd_en = i_mu_ready; o_MU_rd_addr = addr counter; counter increments only on cycles where o_MU_rd_en is high.
REQ-022 READ: i_mu_ready low holds o_MU_rd_addr stable and o_MU_rd_en low; no address is skipped or repeated.
REQ-023 READ: after issuing address cnt_max-1, go to DONE; o_MU_rd_en never asserts for an address >= cnt_max.
REQ-024 DONE: assert o_done for exactly one cycle, then go to IDLE.
REQ-025 o_frc_parid and o_frc_parid_valid SHALL be o_MU_rd_addr and o_MU_rd_en delayed by exactly 1 cycle, matching force cache read latency.
REQ-026 o_MU_rd_en SHALL be 0 in every state other than READ, so cache accumulation and readout never overlap.
REQ-027 The addr counter SHALL be PARTICLE_ID_WIDTH+1 bits so that cnt_max = 2^PARTICLE_ID_WIDTH completes without wrap.

Reset
REQ-028 Asserting rst SHALL immediately force IDLE; o_MU_rd_en, o_frc_parid_valid, o_busy and o_done go to 0, and o_MU_rd_addr and o_frc_parid go to 0.
REQ-029 Reset mid-READ SHALL abandon the readout with no further strobes; the next i_start restarts from address 0.
REQ-030 Reset deassertion SHALL be synchronised internally before it reaches the state register.

Structure
REQ-031 The state enum and the DRAIN_CYCLES default SHALL live in MD_pkg, with PARTICLE_ID_WIDTH reused from MD_pkg.
REQ-032 The block SHALL be one module with no sub-modules; the 1-cycle delay registers SHALL be inline.

Verification
REQ-033 N=4, buffers empty, i_force_done=1, i_mu_ready=1, i_start pulse -> 6 settle cycles, then addr 0,1,2,3 on consecutive cycles, o_frc_parid 0..3 one cycle later, then a single o_done.
REQ-034 N=4, i_mu_ready low on the 2nd READ cycle -> addresses 0,1,2,3 each issued exactly once, addr 1 held during the stall.
REQ-035 i_home_buf_empty drops at settle count 3 -> return to DRAIN, and no o_MU_rd_en until a full 6-cycle settle completes.
REQ-036 N=0 -> o_done pulses after settle with zero read strobes; a second i_start during READ is ignored.
REQ-037 rst asserted after addr 2 of N=8 -> all outputs 0 at once; a new i_start gives a readout beginning at addr 0.

Source files
------------

// File: rtl/MD_pkg.sv
// Shared MD-engine constants and types used by the force readout controller.
package MD_pkg;

    localparam int PARTICLE_ID_WIDTH = 8;
    localparam int FRC_DRAIN_CYCLES  = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_READ   = 3'd3,
        ST_DONE   = 3'd4
    } frc_rd_state_e;

endpackage

// File: rtl/frc_readout_ctrl.sv
// Waits for both force buffers to drain and settle, then streams cache
// read-and-clear addresses to the motion-update consumer under backpressure.
module frc_readout_ctrl #(
    parameter int DRAIN_CYCLES      = MD_pkg::FRC_DRAIN_CYCLES,
    parameter int PARTICLE_ID_WIDTH = MD_pkg::PARTICLE_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [PARTICLE_ID_WIDTH:0]   i_num_particles,
    input  logic                         i_force_done,
    input  logic                         i_home_buf_empty,
    input  logic                         i_nb_buf_empty,
    input  logic                         i_mu_ready,
    output logic [PARTICLE_ID_WIDTH-1:0] o_MU_rd_addr,
    output logic                         o_MU_rd_en,
    output logic [PARTICLE_ID_WIDTH-1:0] o_frc_parid,
    output logic                         o_frc_parid_valid,
    output logic                         o_busy,
    output logic                         o_done
);
    import MD_pkg::*;

    localparam int AW = PARTICLE_ID_WIDTH + 1;
    localparam int SW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [1:0]                   rst_sync_q;
    logic                         rst_n_int;
    frc_rd_state_e                state_q;
    logic [AW-1:0]                addr_q;
    logic [AW-1:0]                cnt_max_q;
    logic [SW-1:0]                settle_q;
    logic [PARTICLE_ID_WIDTH-1:0] parid_q;
    logic                         parid_vld_q;
    logic                         bufs_empty;

    // Assertion reaches the state flops immediately; release is re-timed to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    assign bufs_empty = i_home_buf_empty & i_nb_buf_empty;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_max_q <= '0;
            settle_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        cnt_max_q <= i_num_particles;
                        addr_q    <= '0;
                        state_q   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (i_force_done && bufs_empty) begin
                        settle_q <= SW'(DRAIN_CYCLES - 1);
                        state_q  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Late forces landing in a buffer restart the whole drain check.
                    if (!bufs_empty)
                        state_q <= ST_DRAIN;
                    else if (settle_q == '0)
                        state_q <= (cnt_max_q == '0) ? ST_DONE : ST_READ;
                    else
                        settle_q <= settle_q - SW'(1);
                end
                ST_READ: begin
                    if (i_mu_ready) begin
                        addr_q <= addr_q + AW'(1);
                        if (addr_q + AW'(1) == cnt_max_q) state_q <= ST_DONE;
                    end
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_MU_rd_en   = (state_q == ST_READ) && i_mu_ready;
    assign o_MU_rd_addr = addr_q[PARTICLE_ID_WIDTH-1:0];
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = (state_q == ST_DONE);

    // Tracks the one-cycle read latency of the force cache.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            parid_q     <= '0;
            parid_vld_q <= 1'b0;
        end else begin
            parid_q     <= o_MU_rd_addr;
            parid_vld_q <= o_MU_rd_en;
        end
    end

    assign o_frc_parid       = parid_q;
    assign o_frc_parid_valid = parid_vld_q;

endmodule

// File: tb/tb_frc_readout_ctrl.sv
// Directed plus randomized checks of frc_readout_ctrl against a phase-level model.
module tb_frc_readout_ctrl;

    localparam int W  = 8;
    localparam int DC = 6;
    localparam int P_IDLE = 0, P_WAIT = 1, P_RD = 2, P_DONE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_start = 1'b0;
    logic [W:0]   i_num_particles = '0;
    logic         i_force_done = 1'b0;
    logic         i_home_buf_empty = 1'b1;
    logic         i_nb_buf_empty = 1'b1;
    logic         i_mu_ready = 1'b0;
    logic [W-1:0] o_MU_rd_addr;
    logic         o_MU_rd_en;
    logic [W-1:0] o_frc_parid;
    logic         o_frc_parid_valid;
    logic         o_busy;
    logic         o_done;

    always #5 clk = ~clk;

    frc_readout_ctrl #(.DRAIN_CYCLES(DC), .PARTICLE_ID_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_particles(i_num_particles),
        .i_force_done(i_force_done), .i_home_buf_empty(i_home_buf_empty),
        .i_nb_buf_empty(i_nb_buf_empty), .i_mu_ready(i_mu_ready),
        .o_MU_rd_addr(o_MU_rd_addr), .o_MU_rd_en(o_MU_rd_en),
        .o_frc_parid(o_frc_parid), .o_frc_parid_valid(o_frc_parid_valid),
        .o_busy(o_busy), .o_done(o_done)
    );

    int n_chk = 0, n_fail = 0;
    // Model: phase, run of quiet cycles, target count, next address to hand out.
    int phase = P_IDLE, run = 0, n_tgt = 0, next_addr = 0;
    bit prev_en = 1'b0;
    int prev_addr = 0;
    int strobes, dones, first_rd, cyc_since_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_en;
        exp_en = (phase == P_RD) && i_mu_ready;
        chk("busy", 32'(o_busy), 32'(phase != P_IDLE));
        chk("done", 32'(o_done), 32'(phase == P_DONE));
        chk("rd_en", 32'(o_MU_rd_en), 32'(exp_en));
        if (phase == P_RD) chk("rd_addr", 32'(o_MU_rd_addr), next_addr);
        chk("parid_valid", 32'(o_frc_parid_valid), 32'(prev_en));
        if (prev_en) chk("parid", 32'(o_frc_parid), prev_addr);
        if (o_MU_rd_en === 1'b1) begin
            strobes++;
            if (first_rd < 0) first_rd = cyc_since_start;
        end
        if (o_done === 1'b1) dones++;
    endtask

    // A readout begins once the drain condition is seen and then both
    // buffers stay empty for DC further consecutive cycles.
    task automatic model_update();
        bit en;
        en = (phase == P_RD) && i_mu_ready;
        prev_en = en;
        prev_addr = next_addr;
        case (phase)
            P_IDLE: if (i_start) begin
                phase = P_WAIT; run = 0; n_tgt = int'(i_num_particles); next_addr = 0;
            end
            P_WAIT: begin
                if (run == 0) run = (i_force_done && i_home_buf_empty && i_nb_buf_empty) ? 1 : 0;
                else          run = (i_home_buf_empty && i_nb_buf_empty) ? run + 1 : 0;
                if (run == DC + 1) phase = (n_tgt == 0) ? P_DONE : P_RD;
            end
            P_RD: if (en) begin
                next_addr++;
                if (next_addr == n_tgt) phase = P_DONE;
            end
            default: phase = P_IDLE;
        endcase
    endtask

    task automatic cyc();
        #1 check_outputs();
        @(posedge clk);
        model_update();
        cyc_since_start++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_rd_en", 32'(o_MU_rd_en), 0);
        chk("rst_rd_addr", 32'(o_MU_rd_addr), 0);
        chk("rst_parid", 32'(o_frc_parid), 0);
        chk("rst_parid_valid", 32'(o_frc_parid_valid), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        phase = P_IDLE; prev_en = 1'b0; prev_addr = 0; next_addr = 0;
        @(negedge clk);
        rst = 1'b1;
        i_start = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic run_readout(input int n, input bit rnd, input int stall_at,
                               input int drop_at, input int abort_after, input bit start_in_read);
        int rc;
        rc = 0;
        strobes = 0; dones = 0; first_rd = -1; cyc_since_start = 0;
        i_start = 1'b1; i_num_particles = n[W:0];
        i_force_done = 1'b1; i_home_buf_empty = 1'b1; i_nb_buf_empty = 1'b1; i_mu_ready = 1'b1;
        cyc();
        for (int k = 0; k < 3000 && phase != P_IDLE; k++) begin
            i_start = 1'b0; i_mu_ready = 1'b1; i_force_done = 1'b1;
            i_home_buf_empty = 1'b1; i_nb_buf_empty = 1'b1;
            if (rnd) begin
                i_mu_ready       = ($urandom_range(0, 3) != 0);
                i_home_buf_empty = ($urandom_range(0, 15) != 0);
                i_nb_buf_empty   = ($urandom_range(0, 15) != 0);
                i_force_done     = ($urandom_range(0, 7) != 0);
                i_start          = ($urandom_range(0, 7) == 0);
                i_num_particles  = 9'($urandom_range(0, 511));
            end
            if (phase == P_RD) begin
                if (rc == stall_at) i_mu_ready = 1'b0;
                if (start_in_read) begin i_start = 1'b1; i_num_particles = 9'd3; end
                rc++;
            end
            if (cyc_since_start == drop_at) i_home_buf_empty = 1'b0;
            if (abort_after >= 0 && strobes == abort_after) begin
                do_reset();
                return;
            end
            cyc();
        end
        chk("readout_finished", phase, P_IDLE);
        chk("strobe_count", strobes, n);
        chk("done_count", dones, 1);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        run_readout(4, 1'b0, -1, -1, -1, 1'b0);
        chk("first_rd_basic", first_rd, 8);

        run_readout(4, 1'b0, 1, -1, -1, 1'b0);
        chk("first_rd_stall", first_rd, 8);

        run_readout(4, 1'b0, -1, 4, -1, 1'b0);
        chk("first_rd_resettle", first_rd, 12);

        run_readout(0, 1'b0, -1, -1, -1, 1'b0);
        chk("first_rd_zero", first_rd, -1);

        run_readout(5, 1'b0, -1, -1, -1, 1'b1);

        run_readout(8, 1'b0, -1, -1, 3, 1'b0);
        run_readout(8, 1'b0, -1, -1, -1, 1'b0);

        run_readout(1, 1'b0, -1, -1, -1, 1'b0);
        run_readout(256, 1'b1, -1, -1, -1, 1'b0);

        for (int t = 0; t < 12; t++) run_readout(int'($urandom_range(0, 20)), 1'b1, -1, -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
